// File: rtl/ghost_sprite_reader.sv
// Single-sprite scanline reader: maps the scan position to a sprite RAM address
// and turns the returned color index into a palette color two cycles later.
module ghost_sprite_reader #(
  parameter int          ADDR_WIDTH = 10,
  parameter int          DATA_WIDTH = 2,
  parameter int          SPRITE_W   = 32,
  parameter int          SPRITE_H   = 32,
  parameter logic [11:0] PAL1       = 12'h0AF,
  parameter logic [11:0] PAL2       = 12'h05F,
  parameter logic [11:0] PAL3       = 12'hFFF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [9:0]            x,
  input  logic [9:0]            y,
  input  logic                  video_on,
  input  logic                  frame_tick,
  input  logic [9:0]            pos_x,
  input  logic [9:0]            pos_y,
  input  logic                  flip_in,
  input  logic                  pos_we,
  output logic [ADDR_WIDTH-1:0] ram_addr_r,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  sprite_on,
  output logic [11:0]           sprite_rgb
);

  localparam logic signed [10:0] LP_W_S = 11'(SPRITE_W);
  localparam logic signed [10:0] LP_H_S = 11'(SPRITE_H);
  localparam logic [21:0]        LP_W_U = 22'(SPRITE_W);

  function automatic logic [11:0] pal_lookup(input logic [DATA_WIDTH-1:0] idx);
    logic [11:0] c;
    c = PAL3;
    if (idx == '0)
      c = 12'h000;
    else if (idx == DATA_WIDTH'(1))
      c = PAL1;
    else if (idx == DATA_WIDTH'(2))
      c = PAL2;
    return c;
  endfunction

  logic [9:0] r_pend_x, r_pend_y, r_act_x, r_act_y;
  logic       r_pend_flip, r_act_flip;

  // A same-cycle pos_we bypasses pending so the new position is live right at the tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_x    <= '0;
      r_pend_y    <= '0;
      r_pend_flip <= 1'b0;
      r_act_x     <= '0;
      r_act_y     <= '0;
      r_act_flip  <= 1'b0;
    end else begin
      if (pos_we) begin
        r_pend_x    <= pos_x;
        r_pend_y    <= pos_y;
        r_pend_flip <= flip_in;
      end
      if (frame_tick) begin
        r_act_x    <= pos_we ? pos_x   : r_pend_x;
        r_act_y    <= pos_we ? pos_y   : r_pend_y;
        r_act_flip <= pos_we ? flip_in : r_pend_flip;
      end
    end
  end

  // Stage p0: box test and address, combinational from the scan position
  logic signed [10:0]    w_dx_p0, w_dy_p0;
  logic [10:0]           w_col_p0;
  logic                  w_vld_p0;
  logic [ADDR_WIDTH-1:0] w_addr_p0;

  assign w_dx_p0  = $signed({1'b0, x}) - $signed({1'b0, r_act_x});
  assign w_dy_p0  = $signed({1'b0, y}) - $signed({1'b0, r_act_y});
  assign w_vld_p0 = video_on
                  && (w_dx_p0 >= 11'sd0) && (w_dx_p0 < LP_W_S)
                  && (w_dy_p0 >= 11'sd0) && (w_dy_p0 < LP_H_S);
  assign w_col_p0 = r_act_flip ? $unsigned(LP_W_S - 11'sd1 - w_dx_p0) : $unsigned(w_dx_p0);
  assign w_addr_p0 = ADDR_WIDTH'({11'd0, $unsigned(w_dy_p0)} * LP_W_U + {11'd0, w_col_p0});
  assign ram_addr_r = w_vld_p0 ? w_addr_p0 : '0;

  // Stage p1: box flag lines up with the RAM's registered read data
  logic r_vld_p1;
  logic w_hit_p1;

  assign w_hit_p1 = r_vld_p1 && (ram_dout != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_vld_p1 <= 1'b0;
    else
      r_vld_p1 <= w_vld_p0;
  end

  // Stage p2: registered pixel output, index 0 is transparent
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sprite_on  <= 1'b0;
      sprite_rgb <= 12'h000;
    end else begin
      sprite_on  <= w_hit_p1;
      sprite_rgb <= w_hit_p1 ? pal_lookup(ram_dout) : 12'h000;
    end
  end

endmodule

// File: tb/tb_ghost_sprite_reader.sv
// Directed bench for ghost_sprite_reader with a behavioural registered-read sprite RAM.
module tb_ghost_sprite_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  x, y, pos_x, pos_y;
  logic        video_on, frame_tick, flip_in, pos_we;
  logic [9:0]  ram_addr_r;
  logic [1:0]  ram_dout;
  logic        sprite_on;
  logic [11:0] sprite_rgb;

  logic [1:0]  ram [0:1023];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  always @(posedge clk) ram_dout <= ram[ram_addr_r];

  ghost_sprite_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .x          (x),
    .y          (y),
    .video_on   (video_on),
    .frame_tick (frame_tick),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .flip_in    (flip_in),
    .pos_we     (pos_we),
    .ram_addr_r (ram_addr_r),
    .ram_dout   (ram_dout),
    .sprite_on  (sprite_on),
    .sprite_rgb (sprite_rgb)
  );

  task automatic set_pos(input logic [9:0] px, input logic [9:0] py, input logic f,
                         input logic we, input logic tick);
    @(negedge clk);
    pos_x = px; pos_y = py; flip_in = f; pos_we = we; frame_tick = tick;
    @(negedge clk);
    pos_we = 1'b0; frame_tick = 1'b0;
  endtask

  task automatic drive_xy(input logic [9:0] nx, input logic [9:0] ny);
    @(negedge clk);
    x = nx; y = ny;
    #1;
  endtask

  task automatic pipe_wait();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++; if (sprite_on !== 1'b0) begin errors++; $display("FAIL reset_on got=%0b exp=0", sprite_on); end
    checks++; if (sprite_rgb !== 12'h000) begin errors++; $display("FAIL reset_rgb got=%h exp=000", sprite_rgb); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    video_on = 1'b1;
    drive_xy(10'd0, 10'd0);
    checks++; if (ram_addr_r !== 10'd0) begin errors++; $display("FAIL post_reset_addr got=%0d exp=0", ram_addr_r); end
    pipe_wait();
    checks++; if (sprite_on !== 1'b1) begin errors++; $display("FAIL post_reset_on got=%0b exp=1", sprite_on); end
    checks++; if (sprite_rgb !== 12'h05F) begin errors++; $display("FAIL post_reset_rgb got=%h exp=05F", sprite_rgb); end
    drive_xy(10'd5, 10'd2);
    checks++; if (ram_addr_r !== 10'd69) begin errors++; $display("FAIL post_reset_addr2 got=%0d exp=69", ram_addr_r); end
  endtask

  task automatic test_place();
    set_pos(10'd100, 10'd50, 1'b0, 1'b1, 1'b0);
    set_pos(10'd0, 10'd0, 1'b0, 1'b0, 1'b1);
    drive_xy(10'd100, 10'd50);
    checks++; if (ram_addr_r !== 10'd0) begin errors++; $display("FAIL place_addr got=%0d exp=0", ram_addr_r); end
    pipe_wait();
    checks++; if (sprite_on !== 1'b1) begin errors++; $display("FAIL place_on got=%0b exp=1", sprite_on); end
    checks++; if (sprite_rgb !== 12'h05F) begin errors++; $display("FAIL place_rgb got=%h exp=05F", sprite_rgb); end
  endtask

  task automatic test_back_to_back();
    logic        exp_on  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [11:0] exp_rgb [4] = '{12'h05F, 12'h000, 12'hFFF, 12'h0AF};
    y = 10'd50;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        checks++;
        if (sprite_on !== exp_on[i-2]) begin
          errors++; $display("FAIL b2b_on[%0d] got=%0b exp=%0b", i-2, sprite_on, exp_on[i-2]);
        end
        checks++;
        if (sprite_rgb !== exp_rgb[i-2]) begin
          errors++; $display("FAIL b2b_rgb[%0d] got=%h exp=%h", i-2, sprite_rgb, exp_rgb[i-2]);
        end
      end
      if (i < 4) x = 10'(100 + i);
    end
  endtask

  task automatic test_deferred();
    set_pos(10'd200, 10'd50, 1'b0, 1'b1, 1'b0);
    drive_xy(10'd100, 10'd50);
    pipe_wait();
    checks++; if (sprite_on !== 1'b1) begin errors++; $display("FAIL deferred_old_on got=%0b exp=1", sprite_on); end
    drive_xy(10'd200, 10'd50);
    pipe_wait();
    checks++; if (sprite_on !== 1'b0) begin errors++; $display("FAIL deferred_new_off got=%0b exp=0", sprite_on); end
    set_pos(10'd0, 10'd0, 1'b0, 1'b0, 1'b1);
    drive_xy(10'd200, 10'd50);
    pipe_wait();
    checks++; if (sprite_on !== 1'b1) begin errors++; $display("FAIL deferred_tick_on got=%0b exp=1", sprite_on); end
    drive_xy(10'd100, 10'd50);
    pipe_wait();
    checks++; if (sprite_on !== 1'b0) begin errors++; $display("FAIL deferred_tick_old_off got=%0b exp=0", sprite_on); end
  endtask

  task automatic test_flip();
    set_pos(10'd100, 10'd50, 1'b1, 1'b1, 1'b1);
    drive_xy(10'd100, 10'd51);
    checks++; if (ram_addr_r !== 10'd63) begin errors++; $display("FAIL flip_addr_left got=%0d exp=63", ram_addr_r); end
    pipe_wait();
    checks++; if (sprite_rgb !== 12'h0AF) begin errors++; $display("FAIL flip_rgb_left got=%h exp=0AF", sprite_rgb); end
    drive_xy(10'd131, 10'd51);
    checks++; if (ram_addr_r !== 10'd32) begin errors++; $display("FAIL flip_addr_right got=%0d exp=32", ram_addr_r); end
    pipe_wait();
    checks++; if (sprite_rgb !== 12'hFFF) begin errors++; $display("FAIL flip_rgb_right got=%h exp=FFF", sprite_rgb); end
  endtask

  task automatic test_edge();
    set_pos(10'd620, 10'd470, 1'b0, 1'b1, 1'b1);
    drive_xy(10'd639, 10'd479);
    checks++; if (ram_addr_r !== 10'd307) begin errors++; $display("FAIL edge_addr got=%0d exp=307", ram_addr_r); end
    pipe_wait();
    checks++; if (sprite_on !== 1'b0) begin errors++; $display("FAIL edge_transp_on got=%0b exp=0", sprite_on); end
    checks++; if (sprite_rgb !== 12'h000) begin errors++; $display("FAIL edge_transp_rgb got=%h exp=000", sprite_rgb); end
    drive_xy(10'd0, 10'd0);
    checks++; if (ram_addr_r !== 10'd0) begin errors++; $display("FAIL edge_wrap_addr got=%0d exp=0", ram_addr_r); end
    pipe_wait();
    checks++; if (sprite_on !== 1'b0) begin errors++; $display("FAIL edge_wrap_on got=%0b exp=0", sprite_on); end
    drive_xy(10'd620, 10'd470);
    pipe_wait();
    checks++; if (sprite_rgb !== 12'h05F) begin errors++; $display("FAIL edge_corner_rgb got=%h exp=05F", sprite_rgb); end
  endtask

  task automatic test_bounds();
    set_pos(10'd100, 10'd50, 1'b0, 1'b1, 1'b1);
    video_on = 1'b0;
    drive_xy(10'd110, 10'd60);
    checks++; if (ram_addr_r !== 10'd0) begin errors++; $display("FAIL blank_addr got=%0d exp=0", ram_addr_r); end
    pipe_wait();
    checks++; if (sprite_on !== 1'b0) begin errors++; $display("FAIL blank_on got=%0b exp=0", sprite_on); end
    video_on = 1'b1;
    drive_xy(10'd99, 10'd60);
    pipe_wait();
    checks++; if (sprite_on !== 1'b0) begin errors++; $display("FAIL left_edge_on got=%0b exp=0", sprite_on); end
    drive_xy(10'd132, 10'd60);
    pipe_wait();
    checks++; if (sprite_on !== 1'b0) begin errors++; $display("FAIL right_edge_on got=%0b exp=0", sprite_on); end
    drive_xy(10'd131, 10'd50);
    pipe_wait();
    checks++; if (sprite_on !== 1'b1) begin errors++; $display("FAIL last_col_on got=%0b exp=1", sprite_on); end
    drive_xy(10'd100, 10'd81);
    checks++; if (ram_addr_r !== 10'd992) begin errors++; $display("FAIL last_row_addr got=%0d exp=992", ram_addr_r); end
    drive_xy(10'd100, 10'd82);
    pipe_wait();
    checks++; if (sprite_on !== 1'b0) begin errors++; $display("FAIL below_on got=%0b exp=0", sprite_on); end
  endtask

  task automatic test_reset_mid();
    drive_xy(10'd100, 10'd50);
    pipe_wait();
    checks++; if (sprite_on !== 1'b1) begin errors++; $display("FAIL premid_on got=%0b exp=1", sprite_on); end
    rst_n = 1'b0;
    #1;
    checks++; if (sprite_on !== 1'b0) begin errors++; $display("FAIL mid_reset_on got=%0b exp=0", sprite_on); end
    checks++; if (sprite_rgb !== 12'h000) begin errors++; $display("FAIL mid_reset_rgb got=%h exp=000", sprite_rgb); end
    @(negedge clk);
    rst_n = 1'b1;
    drive_xy(10'd100, 10'd50);
    pipe_wait();
    checks++; if (sprite_on !== 1'b0) begin errors++; $display("FAIL after_reset_old_on got=%0b exp=0", sprite_on); end
    drive_xy(10'd0, 10'd0);
    pipe_wait();
    checks++; if (sprite_on !== 1'b1) begin errors++; $display("FAIL after_reset_origin_on got=%0b exp=1", sprite_on); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 2'd1;
    ram[0]   = 2'd2;
    ram[1]   = 2'd0;
    ram[2]   = 2'd3;
    ram[3]   = 2'd1;
    ram[32]  = 2'd3;
    ram[307] = 2'd0;
    x = '0; y = '0; pos_x = '0; pos_y = '0;
    video_on = 1'b0; frame_tick = 1'b0; flip_in = 1'b0; pos_we = 1'b0;
    test_reset();
    test_place();
    test_back_to_back();
    test_deferred();
    test_flip();
    test_edge();
    test_bounds();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ghost_sprite_reader.md
GHOST_SPRITE_READER -- requirements
Module: ghost_sprite_reader

Interface
REQ-001 Parameter ADDR_WIDTH, default 10: sprite RAM address bits.
REQ-002 Parameter DATA_WIDTH, default 2: color-index bits per sprite pixel.
REQ-003 Parameter SPRITE_W, default 32: sprite width in pixels; SPRITE_W*SPRITE_H SHALL equal 2**ADDR_WIDTH.
REQ-004 Parameter SPRITE_H, default 32: sprite height in pixels.
REQ-005 Parameters PAL1, PAL2, PAL3, defaults 12'h0AF, 12'h05F, 12'hFFF: 12-bit RGB for color indices 1..3.
REQ-006 clk  in  1  system/pixel clock; all state on rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 x, y  in  10 each  current scan pixel coordinates.
REQ-009 video_on  in  1  scan position is in the visible area.
REQ-010 frame_tick  in  1  one-cycle pulse at start of vertical blank.
REQ-011 pos_x, pos_y  in  10 each  requested sprite top-left position.
REQ-012 flip_in  in  1  requested horizontal mirror.
REQ-013 pos_we  in  1  one-cycle strobe: capture pos_x, pos_y, flip_in into pending registers.
REQ-014 ram_addr_r  out  ADDR_WIDTH  read address to the sprite RAM (registered-read, 1-cycle latency).
REQ-015 ram_dout  in  DATA_WIDTH  sprite RAM read data.
REQ-016 sprite_on  out  1  opaque sprite pixel at the delayed scan position.
REQ-017 sprite_rgb  out  12  palette color; 12'h000 when sprite_on=0.

Function
REQ-018 Two position sets SHALL exist: pending (written by pos_we) and active (used for drawing).
REQ-019 On a frame_tick cycle, active SHALL load from pending; the display never changes mid-frame.
REQ-020 pos_we and frame_tick in the same cycle: the new pos values SHALL go to pending and active at that edge.
REQ-021 dx = x - active_x and dy = y - active_y SHALL be computed in 11-bit signed arithmetic; no wrap-around.
REQ-022 in_box = video_on AND 0<=dx<SPRITE_W AND 0<=dy<SPRITE_H.
REQ-023 Column col = dx, or SPRITE_W-1-dx when active flip=1.
REQ-024 ram_addr_r SHALL be dy*SPRITE_W + col, driven combinationally from the cycle-0 inputs.
REQ-025 When in_box=0, ram_addr_r SHALL be 0.
REQ-026 Stage 1 SHALL register in_box, aligned with ram_dout.
REQ-027 Stage 2 SHALL register sprite_on = in_box_d1 AND (ram_dout != 0), plus sprite_rgb.
REQ-028 Total latency from x/y to sprite_on/sprite_rgb SHALL be exactly 2 cycles.
REQ-029 Color index 0 SHALL be transparent: sprite_on=0, sprite_rgb=0.
REQ-030 A sprite partly past x=639 or y=479 SHALL draw only its visible part; x/y outside the box SHALL produce no spurious hits.
REQ-031 The pipeline SHALL advance every cycle; there is no stall input.

Reset
REQ-032 While rst_n=0, all of the following SHALL clear asynchronously: pending and active registers (x=0, y=0, flip=0), pipeline flags, sprite_on=0, sprite_rgb=0.
REQ-033 Reset asserted mid-frame SHALL drop sprite_on the same cycle.
REQ-034 After release, the sprite SHALL draw at (0,0) unflipped until the first frame_tick following a pos_we.

Verification
REQ-035 Place sprite: pos_we with (100,50), then frame_tick. Drive x=100, y=50 with RAM[0]=2 -> 2 cycles later sprite_on=1, sprite_rgb=PAL2.
REQ-036 Deferred update: pos_we with (200,50) mid-frame, no frame_tick. Scan x=100, y=50 -> still drawn at 100; x=200 -> sprite_on=0.
REQ-037 Flip: flip_in=1 applied at a frame_tick, sprite at (100,50). Drive x=100, y=51 -> ram_addr_r=63; drive x=131 -> ram_addr_r=32.
REQ-038 Edge and transparency: sprite at (620,470). Drive x=639, y=479 -> ram_addr_r=9*32+19=307; drive x=0, y=0 -> sprite_on=0. With RAM[307]=0 -> sprite_on=0, sprite_rgb=0.
REQ-039 Boundaries: video_on=0 inside the box -> sprite_on=0; x=active_x-1 and x=active_x+32 -> sprite_on=0.
REQ-040 Reset: assert rst_n=0 while sprite_on=1 -> sprite_on=0 and sprite_rgb=0 immediately; after release, position reads back as (0,0).
